// File: rtl/mat_2x2_operand_loader_if.sv
// Handshake and operand bus between the element stream source, the operand
// loader and the downstream 2x2 multiplier.
interface mat_2x2_operand_loader_if #(
   parameter int ELEM_W = 4
);
   logic [ELEM_W-1:0] in_data;
   logic              in_sof;
   logic              in_valid;
   logic              in_ready;
   logic [ELEM_W-1:0] a;
   logic [ELEM_W-1:0] b;
   logic [ELEM_W-1:0] c;
   logic [ELEM_W-1:0] d;
   logic [ELEM_W-1:0] e;
   logic [ELEM_W-1:0] f;
   logic [ELEM_W-1:0] g;
   logic [ELEM_W-1:0] h;
   logic              mat_valid;
   logic              mat_ready;
   logic              frame_err;

   modport slave (
      input  in_data, in_sof, in_valid, mat_ready,
      output in_ready, a, b, c, d, e, f, g, h, mat_valid, frame_err
   );

   modport master (
      output in_data, in_sof, in_valid, mat_ready,
      input  in_ready, a, b, c, d, e, f, g, h, mat_valid, frame_err
   );
endinterface

// File: rtl/mat_2x2_operand_loader.sv
// Serial-to-parallel operand loader for the 2x2 matrix multiplier.
// Collects eight elements (A = [a b; c d], B = [e f; g h]) and holds them
// on a..h until the multiplier takes the frame.
// Build option: MAT_LOAD_TRANSPOSE_EN -- B arrives column-major (e,g,f,h).
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a start-of-frame element; stray elements flagged
// LOAD  | collecting elements 2..8 of a frame, idx = next slot
// FULL  | frame complete, a..h held, mat_valid high until mat_ready
module mat_2x2_operand_loader #(
   parameter int ELEM_W     = 4,
   parameter int ERR_STICKY = 0
) (
   input logic                      clk,
   input logic                      rst,
   mat_2x2_operand_loader_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_FULL = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [2:0]        idx_q, idx_d;
   logic [ELEM_W-1:0] slot_q [8];
   logic              frame_err_q, frame_err_d;
   logic              wr_en;
   logic [2:0]        wr_slot;
   logic              err_evt;
   logic              accept;

   // Arrival index to operand slot; only B's off-diagonal swaps when transposed.
   function automatic logic [2:0] slot_of(input logic [2:0] i);
`ifdef MAT_LOAD_TRANSPOSE_EN
      case (i)
         3'd5:    return 3'd6;
         3'd6:    return 3'd5;
         default: return i;
      endcase
`else
      return i;
`endif
   endfunction

   assign bus.in_ready  = (state_q != S_FULL);
   assign bus.mat_valid = (state_q == S_FULL);
   assign accept        = bus.in_valid & bus.in_ready;

   // Next-state, slot write select and framing error detection.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      wr_en   = 1'b0;
      wr_slot = 3'd0;
      err_evt = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (bus.in_sof) begin
                  wr_en   = 1'b1;
                  idx_d   = 3'd1;
                  state_d = S_LOAD;
               end else begin
                  err_evt = 1'b1;
               end
            end
         end
         S_LOAD: begin
            if (accept) begin
               if (bus.in_sof) begin
                  // restart: earlier partial slots stay stale until rewritten
                  wr_en   = 1'b1;
                  idx_d   = 3'd1;
                  err_evt = 1'b1;
               end else begin
                  wr_en   = 1'b1;
                  wr_slot = slot_of(idx_q);
                  idx_d   = 3'(idx_q + 3'd1);
                  if (idx_q == 3'd7) begin
                     state_d = S_FULL;
                  end
               end
            end
         end
         S_FULL: begin
            if (bus.mat_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            idx_d   = 3'd0;
         end
      endcase
      if (ERR_STICKY != 0) begin
         frame_err_d = frame_err_q | err_evt;
      end else begin
         frame_err_d = err_evt;
      end
   end

   // State, index and error flag registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         idx_q       <= 3'd0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         frame_err_q <= frame_err_d;
      end
   end

   // Operand slots; written only on an accepted element, otherwise held.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) begin
            slot_q[i] <= '0;
         end
      end else if (wr_en) begin
         slot_q[wr_slot] <= bus.in_data;
      end
   end

   assign bus.a         = slot_q[0];
   assign bus.b         = slot_q[1];
   assign bus.c         = slot_q[2];
   assign bus.d         = slot_q[3];
   assign bus.e         = slot_q[4];
   assign bus.f         = slot_q[5];
   assign bus.g         = slot_q[6];
   assign bus.h         = slot_q[7];
   assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_mat_2x2_operand_loader.sv
// Bench for the operand loader: table of frames plus hand-written
// framing-error and mid-frame reset sequences; expected frames are queued
// when sent and compared when the loader hands them off.
module tb_mat_2x2_operand_loader;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   mat_2x2_operand_loader_if #(.ELEM_W(4)) bus ();

   mat_2x2_operand_loader #(.ELEM_W(4), .ERR_STICKY(0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   logic [31:0] outs;
   assign outs = {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g, bus.h};

   typedef struct packed {
      logic [31:0] elems;
      int          stall;
      logic [31:0] expect_out;
   } vec_t;

   vec_t        tbl [6];
   logic [31:0] exp_q [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference load-order model: element k lands in a..h position k, except
   // that column-major B swaps the f and g positions.
   function automatic logic [31:0] model(input logic [31:0] s);
`ifdef MAT_LOAD_TRANSPOSE_EN
      return {s[31:12], s[7:4], s[11:8], s[3:0]};
`else
      return s;
`endif
   endfunction

   task automatic send(input logic [3:0] d, input logic sof);
      int n;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_sof   = sof;
      n = 0;
      while (!bus.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         errors++;
         checks++;
         $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", n);
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_sof   = 1'b0;
   endtask

   task automatic wait_handoff(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.mat_valid && n < 40);
      if (bus.mat_valid) begin
         errors++;
         checks++;
         $display("FAIL handoff_timeout: mat_valid still 1 after %0d cycles", n);
      end
   endtask

   task automatic send_frame(input logic [31:0] s, input int stall, input logic [31:0] exp);
      int n;
      @(posedge clk);
      #1;
      bus.mat_ready = (stall == 0);
      exp_q.push_back(exp);
      for (int i = 0; i < 8; i++) begin
         send(s[31-4*i -: 4], i == 0);
      end
      @(negedge clk);
      chk("latency_mat_valid", 32'(bus.mat_valid), 32'd1);
      chk("full_in_ready", 32'(bus.in_ready), 32'd0);
      if (stall > 0) begin
         repeat (stall) @(posedge clk);
         #1;
         bus.mat_ready = 1'b1;
      end
      wait_handoff(n);
      if (stall == 0) begin
         chk("valid_pulse_width", 32'(n), 32'd1);
      end
      chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
   endtask

   // Output monitor: hold stability while stalled, scoreboard compare on handoff.
   logic        pv, pr;
   logic [31:0] snap;
   always @(negedge clk) begin
      if (rst) begin
         pv <= 1'b0;
         pr <= 1'b0;
      end else begin
         if (pv && !pr) begin
            chk("stall_mat_valid", 32'(bus.mat_valid), 32'd1);
            chk("stall_hold_ops", outs, snap);
         end
         if (bus.mat_valid && bus.mat_ready) begin
            if (exp_q.size() == 0) begin
               errors++;
               checks++;
               $display("FAIL unexpected_frame: got %h expected none", outs);
            end else begin
               chk("frame_ops", outs, exp_q.pop_front());
            end
         end
         pv   <= bus.mat_valid;
         pr   <= bus.mat_ready;
         snap <= outs;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1);
   end

   initial begin
      tbl[0] = '{elems: 32'h12345678, stall: 0, expect_out: 32'h0};
      tbl[1] = '{elems: 32'h12345678, stall: 5, expect_out: 32'h0};
      tbl[2] = '{elems: 32'hFFFFFFFF, stall: 0, expect_out: 32'h0};
      tbl[3] = '{elems: 32'h00000000, stall: 2, expect_out: 32'h0};
      tbl[4] = '{elems: 32'hA5C30F69, stall: 1, expect_out: 32'h0};
      tbl[5] = '{elems: $urandom(),   stall: 3, expect_out: 32'h0};
      foreach (tbl[i]) tbl[i].expect_out = model(tbl[i].elems);

      bus.in_valid  = 1'b0;
      bus.in_sof    = 1'b0;
      bus.in_data   = 4'h0;
      bus.mat_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      @(negedge clk);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_mat_valid", 32'(bus.mat_valid), 32'd0);
      chk("rst_frame_err", 32'(bus.frame_err), 32'd0);
      chk("rst_ops", outs, 32'h0);

      // stray element in IDLE
      send(4'h5, 1'b0);
      @(negedge clk);
      chk("stray_frame_err", 32'(bus.frame_err), 32'd1);
      chk("stray_ops", outs, 32'h0);
      chk("stray_mat_valid", 32'(bus.mat_valid), 32'd0);
      @(negedge clk);
      chk("stray_err_clear", 32'(bus.frame_err), 32'd0);
      chk("stray_in_ready", 32'(bus.in_ready), 32'd1);

      for (int i = 0; i < 6; i++) begin
         send_frame(tbl[i].elems, tbl[i].stall, tbl[i].expect_out);
      end

      // restart mid-frame with a new sof
      exp_q.push_back(model(32'h9ABCDEF0));
      send(4'h1, 1'b1);
      send(4'h2, 1'b0);
      send(4'h3, 1'b0);
      chk("restart_no_err_yet", 32'(bus.frame_err), 32'd0);
      send(4'h9, 1'b1);
      @(negedge clk);
      chk("restart_frame_err", 32'(bus.frame_err), 32'd1);
      send(4'hA, 1'b0);
      @(negedge clk);
      chk("restart_err_pulse", 32'(bus.frame_err), 32'd0);
      send(4'hB, 1'b0);
      send(4'hC, 1'b0);
      send(4'hD, 1'b0);
      send(4'hE, 1'b0);
      send(4'hF, 1'b0);
      send(4'h0, 1'b0);
      begin
         int n;
         @(negedge clk);
         chk("restart_mat_valid", 32'(bus.mat_valid), 32'd1);
         chk("restart_no_extra_err", 32'(bus.frame_err), 32'd0);
         wait_handoff(n);
      end

      // reset after five elements of a frame
      send(4'h7, 1'b1);
      send(4'h6, 1'b0);
      send(4'h5, 1'b0);
      send(4'h4, 1'b0);
      send(4'h3, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_ops", outs, 32'h0);
      chk("midrst_mat_valid", 32'(bus.mat_valid), 32'd0);
      chk("midrst_frame_err", 32'(bus.frame_err), 32'd0);
      chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
      send_frame(tbl[0].elems, 0, tbl[0].expect_out);

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
